// File: rtl/aska_spi_master.sv
// rtl/aska_spi_master.sv - write-only SPI mode-0 master that sends 40-bit address+data frames to ASKA
module aska_spi_master #(
  parameter int CLK_DIV  = 1,
  parameter int CS_LEAD  = 4,
  parameter int CS_TRAIL = 4,
  parameter int CS_GAP   = 20
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        SPI_CS,
  output logic        SPI_Clk,
  output logic        SPI_MOSI
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_LOW,
    S_HIGH,
    S_TRAIL,
    S_GAP
  } state_t;

  localparam int TW = 16;
  localparam logic [TW-1:0] LEAD_T  = TW'(CS_LEAD - 1);
  localparam logic [TW-1:0] HALF_T  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TRAIL_T = TW'(CS_TRAIL - 1);
  localparam logic [TW-1:0] GAP_T   = (CS_GAP > 0) ? TW'(CS_GAP - 1) : '0;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [39:0]   shreg_q, shreg_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          abt_q, abt_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          ready_q, ready_d;

  // MOSI is the top of the shift register, which is cleared whenever the frame leaves the bit phases
  assign SPI_MOSI  = shreg_q[39];
  assign SPI_CS    = cs_q;
  assign SPI_Clk   = sclk_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign cmd_ready = ready_q;

  // Next-state logic for the frame sequencer and all registered outputs
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    abt_d     = abt_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        // abort is deliberately not looked at here, even in the handshake cycle
        if (cmd_valid) begin
          shreg_d   = {cmd_addr, cmd_data};
          cnt_d     = 6'd40;
          abt_d     = 1'b0;
          aborted_d = 1'b0;
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          tmr_d     = LEAD_T;
          state_d   = S_LEAD;
        end
      end
      S_LEAD, S_LOW: begin
        if (abort) begin
          abt_d   = 1'b1;
          shreg_d = '0;
          tmr_d   = TRAIL_T;
          state_d = S_TRAIL;
        end else if (tmr_q == '0) begin
          tmr_d   = HALF_T;
          if (state_q == S_LEAD) begin
            state_d = S_LOW;
          end else begin
            sclk_d  = 1'b1;
            state_d = S_HIGH;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_HIGH: begin
        // an abort here is remembered so the high phase is never cut short
        abt_d = abt_q | abort;
        if (tmr_q == '0) begin
          sclk_d = 1'b0;
          cnt_d  = cnt_q - 6'd1;
          if (abt_d || cnt_d == 6'd0) begin
            shreg_d = '0;
            tmr_d   = TRAIL_T;
            state_d = S_TRAIL;
          end else begin
            shreg_d = {shreg_q[38:0], 1'b0};
            tmr_d   = HALF_T;
            state_d = S_LOW;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_TRAIL: begin
        if (tmr_q == '0) begin
          cs_d      = 1'b1;
          done_d    = 1'b1;
          aborted_d = abt_q;
          if (CS_GAP == 0) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            tmr_d   = GAP_T;
            state_d = S_GAP;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_GAP: begin
        if (tmr_q == '0) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset forces chip select high at once
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      abt_q     <= 1'b0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      abt_q     <= abt_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      ready_q   <= ready_d;
    end
  end

endmodule

// File: tb/tb_aska_spi_master.sv
// tb/tb_aska_spi_master.sv - scoreboard bench for aska_spi_master
`timescale 1ns/1ps
module tb_aska_spi_master;

  typedef struct {
    int          inst;
    logic [39:0] cap;
    int          edges;
    int          cs_low;
    logic        abt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_l;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [7:0]  cmd_addr  [2];
  logic [31:0] cmd_data  [2];
  logic        abort     [2];
  logic        busy      [2];
  logic        done      [2];
  logic        aborted   [2];
  logic        cs        [2];
  logic        sclk      [2];
  logic        mosi      [2];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  aska_spi_master u_dut0 (
    .clk(clk), .reset_l(reset_l),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]),
    .abort(abort[0]), .busy(busy[0]), .done(done[0]), .aborted(aborted[0]),
    .SPI_CS(cs[0]), .SPI_Clk(sclk[0]), .SPI_MOSI(mosi[0])
  );

  aska_spi_master #(.CLK_DIV(3)) u_dut1 (
    .clk(clk), .reset_l(reset_l),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]),
    .abort(abort[1]), .busy(busy[1]), .done(done[1]), .aborted(aborted[1]),
    .SPI_CS(cs[1]), .SPI_Clk(sclk[1]), .SPI_MOSI(mosi[1])
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave model and scoreboard: one per instance, sampled on the falling clk edge
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic        cs_p = 1'b1, sclk_p = 1'b0, mosi_p = 1'b0, hi_valid = 1'b0;
    int          low_n = 0, hi_n = 0, edges = 0, viol = 0, gap_n = -1;
    logic [39:0] cap = '0;
    exp_t        e;
    always @(negedge clk) begin
      if (!reset_l) begin
        cs_p = 1'b1; sclk_p = 1'b0; mosi_p = 1'b0; hi_valid = 1'b0;
        low_n = 0; hi_n = 0; edges = 0; viol = 0; gap_n = -1; cap = '0;
      end else begin
        if (cs[g] == 1'b0) begin
          if (cs_p) begin
            if (hi_valid) chk("cs_high_gap", longint'(hi_n >= 21), 1);
            low_n = 0; edges = 0; viol = 0; cap = '0;
          end else if (mosi[g] != mosi_p && !(sclk_p && !sclk[g])) begin
            viol++;
          end
          low_n++;
          if (sclk[g] && !sclk_p) begin
            edges++;
            cap = {cap[38:0], mosi[g]};
          end
          chk("done_while_cs_low", longint'(done[g]), 0);
        end else begin
          if (!cs_p) begin
            chk("done_at_cs_rise", longint'(done[g]), 1);
            chk("frame_expected", longint'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("frame_inst", g, e.inst);
              chk("frame_data", cap, e.cap);
              chk("frame_edges", edges, e.edges);
              chk("frame_cs_low", low_n, e.cs_low);
              chk("frame_aborted", longint'(aborted[g]), longint'(e.abt));
              if (!e.abt) chk("mosi_change_off_fall", viol, 0);
            end
            gap_n = 0; hi_n = 0; hi_valid = 1'b1;
          end else begin
            chk("done_spurious", longint'(done[g]), 0);
          end
          hi_n++;
        end
        if (gap_n >= 0) begin
          if (cmd_ready[g]) begin
            chk("ready_after_done", gap_n, 20);
            gap_n = -1;
          end else if (gap_n > 5000) begin
            chk("ready_after_done", gap_n, 20);
            gap_n = -1;
          end else begin
            gap_n++;
          end
        end
        cs_p = cs[g]; sclk_p = sclk[g]; mosi_p = mosi[g];
      end
    end
  end

  task automatic send(input int i, input logic [7:0] a, input logic [31:0] d, input int ne,
                      input int low, input logic abt, input bit keep, input bit expect_frame);
    exp_t        e;
    logic [39:0] f;
    int          n = 0;
    f = {a, d};
    if (expect_frame) begin
      e.inst = i; e.cap = f >> (40 - ne); e.edges = ne; e.cs_low = low; e.abt = abt;
      exp_q.push_back(e);
    end
    cmd_addr[i] = a; cmd_data[i] = d; cmd_valid[i] = 1'b1;
    while (!cmd_ready[i] && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    chk("handshake_wait", longint'(cmd_ready[i]), 1);
    @(posedge clk); #1;
    if (!keep) cmd_valid[i] = 1'b0;
    cmd_addr[i] = 8'($urandom);
    cmd_data[i] = $urandom;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((busy[i] || !cmd_ready[i]) && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", longint'(busy[i]), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_edges(input int i, input int n);
    int   c = 0, t = 0;
    logic p;
    p = sclk[i];
    while (c < n && t < 5000) begin
      @(negedge clk);
      if (sclk[i] && !p) c++;
      p = sclk[i];
      t++;
    end
    chk("edge_wait", c, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_l = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_addr[i] = '0; cmd_data[i] = '0; abort[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", longint'(cs[0]), 1);
    chk("rst_sclk", longint'(sclk[0]), 0);
    chk("rst_mosi", longint'(mosi[0]), 0);
    chk("rst_done", longint'(done[0]), 0);
    chk("rst_aborted", longint'(aborted[0]), 0);
    chk("rst_busy", longint'(busy[0]), 0);
    chk("rst_ready", longint'(cmd_ready[0]), 1);
    reset_l = 1'b1;
    @(posedge clk); #1;

    // plain frame: 4 lead + 80 bit cycles + 4 trail
    send(0, 8'h02, 32'h0000_8000, 40, 88, 1'b0, 1'b0, 1'b1);
    wait_idle(0);

    // back-to-back with cmd_valid held high
    send(0, 8'h03, 32'h0000_4000, 40, 88, 1'b0, 1'b1, 1'b1);
    send(0, 8'h00, 32'hA5C3_0F1E, 40, 88, 1'b0, 1'b0, 1'b1);
    wait_idle(0);

    // abort during the 32nd high phase: 4 + 64 + 4 cycles of CS low
    send(0, 8'h01, 32'hDEAD_BEEF, 32, 72, 1'b1, 1'b0, 1'b1);
    wait_edges(0, 32);
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    wait_idle(0);
    chk("aborted_held", longint'(aborted[0]), 1);

    // abort coinciding with the handshake is ignored and the handshake clears aborted
    abort[0] = 1'b1;
    send(0, 8'h02, 32'h0F0F_00FF, 40, 88, 1'b0, 1'b0, 1'b1);
    abort[0] = 1'b0;
    chk("aborted_cleared", longint'(aborted[0]), 0);
    wait_idle(0);

    // abort during lead: one lead cycle then trail, no clock edges
    send(0, 8'h03, 32'h1111_1111, 0, 5, 1'b1, 1'b0, 1'b1);
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    wait_idle(0);

    // cmd_valid toggling while busy must not disturb the frame or start another
    send(0, 8'h00, 32'h0000_0001, 40, 88, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++) begin
      cmd_valid[0] = k[0];
      cmd_addr[0]  = 8'($urandom);
      cmd_data[0]  = $urandom;
      @(posedge clk); #1;
    end
    cmd_valid[0] = 1'b0;
    wait_idle(0);

    // reset after 10 bits: frame discarded, no done
    send(0, 8'h01, 32'hCAFE_F00D, 40, 88, 1'b0, 1'b0, 1'b0);
    wait_edges(0, 10);
    @(posedge clk); #1;
    reset_l = 1'b0;
    #1;
    chk("midrst_cs", longint'(cs[0]), 1);
    chk("midrst_sclk", longint'(sclk[0]), 0);
    @(posedge clk); #1;
    reset_l = 1'b1;
    chk("midrst_ready", longint'(cmd_ready[0]), 1);
    chk("midrst_busy", longint'(busy[0]), 0);
    chk("midrst_done", longint'(done[0]), 0);
    @(posedge clk); #1;
    send(0, 8'h02, 32'h8000_0001, 40, 88, 1'b0, 1'b0, 1'b1);
    wait_idle(0);

    // CLK_DIV=3 instance: 4 + 240 + 4 cycles of CS low
    send(1, 8'h02, 32'h0000_8000, 40, 248, 1'b0, 1'b0, 1'b1);
    wait_idle(1);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
